// File: rtl/hazard_ctrl_pkg.sv
// Shared types and default constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

  // Controller states; encodings are fixed (RUN=0, LU_STALL=1, FLUSH=2).
  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StLuStall = 2'd1,
    StFlush   = 2'd2
  } state_e;

  localparam int unsigned DefRegAw    = 5;
  localparam int unsigned DefNumSrc   = 2;
  localparam int unsigned DefLuCyc    = 1;
  localparam int unsigned DefFlushCyc = 1;
  localparam int unsigned DefCntW     = 16;

  // Width of the shared stall/flush down-counter (holds up to 7).
  localparam int unsigned CtrW = 3;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller.
interface hazard_ctrl_if
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW  = DefRegAw,
  parameter int unsigned NUM_SRC = DefNumSrc,
  parameter int unsigned CNT_W   = DefCntW
) ();

  logic [NUM_SRC*REG_AW-1:0] id_rs_addr_i;
  logic [NUM_SRC-1:0]        id_rs_used_i;
  logic                      ex_memread_i;
  logic [REG_AW-1:0]         ex_rd_addr_i;
  logic                      mem_req_i;
  logic                      mem_ready_i;
  logic                      branch_taken_i;
  logic                      perf_clr_i;
  logic                      pc_write_o;
  logic                      if_id_write_o;
  logic                      id_ex_bubble_o;
  logic                      if_id_flush_o;
  logic                      freeze_o;
  logic [CNT_W-1:0]          stall_cnt_o;

  // Pipeline side: drives hazard sources, consumes control.
  modport master (
    output id_rs_addr_i, id_rs_used_i, ex_memread_i, ex_rd_addr_i, mem_req_i, mem_ready_i,
           branch_taken_i, perf_clr_i,
    input  pc_write_o, if_id_write_o, id_ex_bubble_o, if_id_flush_o, freeze_o, stall_cnt_o
  );

  // Controller side.
  modport slave (
    input  id_rs_addr_i, id_rs_used_i, ex_memread_i, ex_rd_addr_i, mem_req_i, mem_ready_i,
           branch_taken_i, perf_clr_i,
    output pc_write_o, if_id_write_o, id_ex_bubble_o, if_id_flush_o, freeze_o, stall_cnt_o
  );

endinterface

// File: rtl/hazard_cmp.sv
// Single-operand compare: does a read source match the EX destination.
module hazard_cmp #(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_addr_i,
  input  logic              used_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  output logic              hit_o
);

  assign hit_o = used_i && (rs_addr_i == rd_addr_i);

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall, branch flush and memory freeze control with stall counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW    = DefRegAw,
  parameter int unsigned NUM_SRC   = DefNumSrc,
  parameter int unsigned LU_CYC    = DefLuCyc,
  parameter int unsigned FLUSH_CYC = DefFlushCyc,
  parameter int unsigned CNT_W     = DefCntW
) (
  input logic         clk_i,
  input logic         rst_i,
  hazard_ctrl_if.slave bus
);

  localparam logic [CtrW-1:0] LuLoad = CtrW'(LU_CYC - 1);
  localparam logic [CtrW-1:0] FlLoad = CtrW'(FLUSH_CYC - 1);

  state_e            state_q, state_d;
  logic [CtrW-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [NUM_SRC-1:0] src_hit;
  logic              lu_hit, freeze;
  logic              pc_wr, ifid_wr, bubble, flush;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_cmp
    hazard_cmp #(.REG_AW(REG_AW)) u_cmp (
      .rs_addr_i(bus.id_rs_addr_i[k*REG_AW +: REG_AW]),
      .used_i   (bus.id_rs_used_i[k]),
      .rd_addr_i(bus.ex_rd_addr_i),
      .hit_o    (src_hit[k])
    );
  end

  // r0 is never a real producer, so a load to it cannot create a hazard.
  assign lu_hit = bus.ex_memread_i && (bus.ex_rd_addr_i != '0) && (|src_hit);
  assign freeze = bus.mem_req_i && !bus.mem_ready_i;

  // Next state, counter and raw control outputs; a freeze holds everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_wr   = 1'b1;
    ifid_wr = 1'b1;
    bubble  = 1'b0;
    flush   = 1'b0;
    if (freeze) begin
      pc_wr   = 1'b0;
      ifid_wr = 1'b0;
    end else begin
      case (state_q)
        StRun: begin
          if (bus.branch_taken_i) begin
            flush = 1'b1;
            if (FLUSH_CYC > 1) begin
              state_d = StFlush;
              cnt_d   = FlLoad;
            end
          end else if (lu_hit) begin
            bubble  = 1'b1;
            pc_wr   = 1'b0;
            ifid_wr = 1'b0;
            if (LU_CYC > 1) begin
              state_d = StLuStall;
              cnt_d   = LuLoad;
            end
          end
        end
        StLuStall: begin
          bubble  = 1'b1;
          pc_wr   = 1'b0;
          ifid_wr = 1'b0;
          if (cnt_q == CtrW'(1)) begin
            state_d = StRun;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CtrW'(1);
          end
        end
        StFlush: begin
          flush = 1'b1;
          if (bus.branch_taken_i) begin
            cnt_d = FlLoad;
          end else if (cnt_q == CtrW'(1)) begin
            state_d = StRun;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CtrW'(1);
          end
        end
        default: begin
          state_d = StRun;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are forced to their idle values while reset is held.
  assign bus.pc_write_o     = pc_wr || !rst_i;
  assign bus.if_id_write_o  = ifid_wr || !rst_i;
  assign bus.id_ex_bubble_o = bubble && rst_i;
  assign bus.if_id_flush_o  = flush && rst_i;
  assign bus.freeze_o       = freeze && rst_i;
  assign bus.stall_cnt_o    = stall_cnt_q;

  // FSM state and shared down-counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Saturating count of cycles where the PC did not advance; clear wins.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
    end else if (bus.perf_clr_i) begin
      stall_cnt_q <= '0;
    end else if (!pc_wr && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Two controller configurations driven in lockstep and checked against a
// remaining-cycles reference model.
module tb_hazard_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [4:0] rs0, rs1, rd;
  logic [1:0] used;
  logic       mr, req, rdy, br, clr;

  int checks = 0;
  int errors = 0;

  // Per-configuration parameters: index 0 = A, index 1 = B.
  int lu_cyc[2] = '{1, 3};
  int fl_cyc[2] = '{2, 2};
  int cmax[2]   = '{65535, 15};
  // Model state: remaining bubble / flush cycles after the current one.
  int lu_rem[2];
  int fl_rem[2];
  int cnt[2];

  always #5 clk_i = ~clk_i;

  hazard_ctrl_if #(.REG_AW(5), .NUM_SRC(2), .CNT_W(16)) ifa ();
  hazard_ctrl_if #(.REG_AW(5), .NUM_SRC(2), .CNT_W(4))  ifb ();

  assign ifa.id_rs_addr_i = {rs1, rs0};
  assign ifa.id_rs_used_i = used;
  assign ifa.ex_memread_i = mr;
  assign ifa.ex_rd_addr_i = rd;
  assign ifa.mem_req_i = req;
  assign ifa.mem_ready_i = rdy;
  assign ifa.branch_taken_i = br;
  assign ifa.perf_clr_i = clr;
  assign ifb.id_rs_addr_i = {rs1, rs0};
  assign ifb.id_rs_used_i = used;
  assign ifb.ex_memread_i = mr;
  assign ifb.ex_rd_addr_i = rd;
  assign ifb.mem_req_i = req;
  assign ifb.mem_ready_i = rdy;
  assign ifb.branch_taken_i = br;
  assign ifb.perf_clr_i = clr;

  hazard_ctrl #(.REG_AW(5), .NUM_SRC(2), .LU_CYC(1), .FLUSH_CYC(2), .CNT_W(16)) dut_a (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (ifa)
  );

  hazard_ctrl #(.REG_AW(5), .NUM_SRC(2), .LU_CYC(3), .FLUSH_CYC(2), .CNT_W(4)) dut_b (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (ifb)
  );

  function automatic logic hit_now();
    return mr && (rd != 5'd0) && ((used[0] && rs0 == rd) || (used[1] && rs1 == rd));
  endfunction

  // Expected {pc_write, if_id_write, bubble, flush, freeze}.
  function automatic logic [4:0] exp_vec(int i);
    if (!rst_i) return 5'b11000;
    if (req && !rdy) return 5'b00001;
    if (lu_rem[i] > 0) return 5'b00100;
    if (fl_rem[i] > 0) return 5'b11010;
    if (br) return 5'b11010;
    if (hit_now()) return 5'b00100;
    return 5'b11000;
  endfunction

  function automatic logic [4:0] obs_vec(int i);
    if (i == 0)
      return {ifa.pc_write_o, ifa.if_id_write_o, ifa.id_ex_bubble_o, ifa.if_id_flush_o,
              ifa.freeze_o};
    return {ifb.pc_write_o, ifb.if_id_write_o, ifb.id_ex_bubble_o, ifb.if_id_flush_o,
            ifb.freeze_o};
  endfunction

  function automatic int obs_cnt(int i);
    return (i == 0) ? int'(ifa.stall_cnt_o) : int'(ifb.stall_cnt_o);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      lu_rem[i] = 0;
      fl_rem[i] = 0;
      cnt[i]    = 0;
    end
  endtask

  // Advance the model across one rising edge using the pre-edge inputs.
  task automatic model_edge();
    logic [4:0] e;
    if (!rst_i) begin
      model_clear();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      e = exp_vec(i);
      if (clr) cnt[i] = 0;
      else if (!e[4] && cnt[i] < cmax[i]) cnt[i]++;
      if (!(req && !rdy)) begin
        if (lu_rem[i] > 0) lu_rem[i]--;
        else if (fl_rem[i] > 0) fl_rem[i] = br ? fl_cyc[i] - 1 : fl_rem[i] - 1;
        else if (br) fl_rem[i] = fl_cyc[i] - 1;
        else if (hit_now()) lu_rem[i] = lu_cyc[i] - 1;
      end
    end
  endtask

  task automatic check_now();
    for (int i = 0; i < 2; i++) begin
      checks++;
      assert (obs_vec(i) === exp_vec(i)) else begin
        errors++;
        $error("FAIL ctrl dut%0d obs=%b exp=%b", i, obs_vec(i), exp_vec(i));
      end
      checks++;
      assert (obs_cnt(i) === cnt[i]) else begin
        errors++;
        $error("FAIL stall_cnt dut%0d obs=%0d exp=%0d", i, obs_cnt(i), cnt[i]);
      end
    end
  endtask

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // One cycle: check at the falling edge, then step the model at the rising edge.
  task automatic tick();
    @(negedge clk_i);
    check_now();
    @(posedge clk_i);
    model_edge();
    #1;
  endtask

  task automatic set_in(logic [4:0] a0, logic [4:0] a1, logic [1:0] u, logic m,
                        logic [4:0] d, logic q, logic y, logic b);
    rs0 = a0; rs1 = a1; used = u; mr = m; rd = d; req = q; rdy = y; br = b;
  endtask

  task automatic idle();
    set_in(5'd1, 5'd2, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    clr = 1'b0;
  endtask

  task automatic lu_hit_in();
    set_in(5'd5, 5'd2, 2'b01, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    model_clear();
    tick();
    rst_i = 1'b1;
  endtask

  initial begin
    idle();
    rst_i = 1'b0;
    model_clear();
    #3;
    check_now();
    tick();
    rst_i = 1'b1;

    // Single load-use hit.
    lu_hit_in(); tick();
    idle(); tick(); tick(); tick();
    chk("lu1_cnt_a", obs_cnt(0), 1);
    chk("lu3_cnt_b", obs_cnt(1), 3);

    // Hits on r0 and on an unused operand must not stall.
    set_in(5'd0, 5'd0, 2'b11, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0); tick();
    set_in(5'd1, 5'd5, 2'b01, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0); tick();
    idle(); tick();
    chk("nohit_cnt_a", obs_cnt(0), 1);
    chk("nohit_cnt_b", obs_cnt(1), 3);

    // Freeze for 4 cycles during the second stall cycle.
    do_reset();
    lu_hit_in(); tick();
    idle(); req = 1'b1;
    repeat (4) tick();
    idle();
    repeat (4) tick();
    chk("freeze_cnt_a", obs_cnt(0), 5);
    chk("freeze_cnt_b", obs_cnt(1), 7);

    // Taken branch together with a load-use hit.
    do_reset();
    lu_hit_in(); br = 1'b1; tick();
    br = 1'b0; tick();
    idle(); tick(); tick();
    chk("br_cnt_a", obs_cnt(0), 0);
    chk("br_cnt_b", obs_cnt(1), 0);

    // Reset asserted while B is mid-stall.
    do_reset();
    lu_hit_in(); tick();
    idle();
    rst_i = 1'b0;
    model_clear();
    #1;
    check_now();
    chk("rst_pc_b", int'(ifb.pc_write_o), 1);
    chk("rst_bub_b", int'(ifb.id_ex_bubble_o), 0);
    tick();
    rst_i = 1'b1;
    tick();
    lu_hit_in(); tick();
    idle(); repeat (3) tick();

    // Saturation and clear alongside a stall.
    do_reset();
    lu_hit_in();
    repeat (20) tick();
    chk("sat_cnt_a", obs_cnt(0), 20);
    chk("sat_cnt_b", obs_cnt(1), 15);
    clr = 1'b1; tick();
    chk("clr_cnt_a", obs_cnt(0), 0);
    chk("clr_cnt_b", obs_cnt(1), 0);
    idle(); tick();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      rs0  = 5'($urandom_range(0, 3));
      rs1  = 5'($urandom_range(0, 3));
      rd   = 5'($urandom_range(0, 3));
      used = 2'($urandom_range(0, 3));
      mr   = ($urandom_range(0, 1) == 1);
      req  = ($urandom_range(0, 9) < 3);
      rdy  = ($urandom_range(0, 1) == 1);
      br   = ($urandom_range(0, 99) < 15);
      clr  = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter REG_AW, default 5, meaning the register address width.
REQ-002 The block SHALL have parameter NUM_SRC, default 2, meaning the number of ID-stage source operands checked.
REQ-003 The block SHALL have parameter LU_CYC, default 1, range 1..7, meaning the bubble cycles per load-use hazard.
REQ-004 The block SHALL have parameter FLUSH_CYC, default 1, range 1..7, meaning the IF/ID flush cycles per taken branch.
REQ-005 The block SHALL have parameter CNT_W, default 16, meaning the stall-counter width.
REQ-006 The block SHALL have one clock and an asynchronous, active-low reset; ports are listed below.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- id_rs_addr_i  in  NUM_SRC*REG_AW  ID source addresses; operand k occupies bits [k*REG_AW +: REG_AW].
- id_rs_used_i  in  NUM_SRC  per-operand "operand read" qualifier.
- ex_memread_i  in  1  EX-stage instruction is a load.
- ex_rd_addr_i  in  REG_AW  EX-stage destination address.
- mem_req_i  in  1  MEM-stage data-memory access pending.
- mem_ready_i  in  1  data memory completes this cycle.
- branch_taken_i  in  1  taken branch resolved this cycle.
- perf_clr_i  in  1  synchronous clear of stall_cnt_o.
- pc_write_o  out  1  PC update enable.
- if_id_write_o  out  1  IF/ID register write enable.
- id_ex_bubble_o  out  1  zero the ID/EX control fields.
- if_id_flush_o  out  1  clear the IF/ID register.
- freeze_o  out  1  hold ID/EX, EX/MEM and MEM/WB.
- stall_cnt_o  out  CNT_W  count of cycles with pc_write_o=0.

Function
REQ-007 lu_hit SHALL be 1 when ex_memread_i=1, ex_rd_addr_i!=0, and at least one k has id_rs_used_i[k]=1 and operand k equal to ex_rd_addr_i.
REQ-008 freeze_o SHALL equal mem_req_i AND NOT mem_ready_i in every state, combinationally.
REQ-009 While freeze_o=1, pc_write_o and if_id_write_o SHALL be 0, id_ex_bubble_o and if_id_flush_o SHALL be 0, and the FSM state and down-counter SHALL hold.
REQ-010 The FSM SHALL have three states: RUN, LU_STALL and FLUSH, with a shared 3-bit down-counter.
REQ-011 In RUN, without freeze: if branch_taken_i=1, the block SHALL assert if_id_flush_o the same cycle, and SHALL load FLUSH_CYC-1 and go to FLUSH if FLUSH_CYC>1; a taken branch outranks lu_hit.
REQ-012 Otherwise in RUN, if lu_hit=1, the block SHALL assert id_ex_bubble_o=1, pc_write_o=0 and if_id_write_o=0 the same cycle, and SHALL load LU_CYC-1 and go to LU_STALL if LU_CYC>1.
REQ-013 Otherwise in RUN, pc_write_o and if_id_write_o SHALL be 1 and all other control outputs SHALL be 0.
REQ-014 In LU_STALL, outputs SHALL be as in REQ-012; the counter decrements each unfrozen cycle; at count 1 the state SHALL return to RUN.
REQ-015 In FLUSH, if_id_flush_o SHALL be 1 and pc_write_o SHALL be 1; the counter decrements each unfrozen cycle; at count 1 the state SHALL return to RUN.
REQ-016 branch_taken_i SHALL be ignored in LU_STALL; in FLUSH it SHALL reload FLUSH_CYC-1.
REQ-017 stall_cnt_o SHALL increment by 1 on each clock edge at which pc_write_o=0, and SHALL saturate at all-ones.
REQ-018 perf_clr_i SHALL zero stall_cnt_o and SHALL take priority over the increment.

Reset
REQ-019 When rst_i=0, the block SHALL force state RUN, counter 0 and stall_cnt_o=0 asynchronously.
REQ-020 While rst_i=0, the outputs SHALL be pc_write_o=1, if_id_write_o=1 and all other outputs 0, regardless of the inputs.
REQ-021 On release of rst_i, the block SHALL operate from RUN on the first rising edge of clk_i.

Structure
REQ-022 A shared package SHALL hold the FSM state enum (RUN=0, LU_STALL=1, FLUSH=2) and the default parameter constants.
REQ-023 The operand compare SHALL be a sub-module hazard_cmp, instantiated NUM_SRC times and OR-reduced.

Verification
REQ-024 The bench SHALL cover: ex_memread_i=1, ex_rd=5, operand0=5 used, LU_CYC=1 -> pc_write_o=0 and id_ex_bubble_o=1 for exactly 1 cycle, and stall_cnt_o=1.
REQ-025 The bench SHALL cover: the same hit with ex_rd=0, or with operand1=5 and id_rs_used_i[1]=0 -> no stall.
REQ-026 The bench SHALL cover: LU_CYC=3, with a mem_req_i=1 / mem_ready_i=0 freeze for 4 cycles in the second stall cycle -> counter holds, and total pc_write_o=0 cycles = 7.
REQ-027 The bench SHALL cover: branch_taken_i and lu_hit together, FLUSH_CYC=2 -> if_id_flush_o=1 for 2 cycles and id_ex_bubble_o stays 0.
REQ-028 The bench SHALL cover: rst_i asserted mid-LU_STALL -> outputs go to their reset values immediately, and RUN behaviour holds after release.
REQ-029 The bench SHALL cover: stall_cnt_o preloaded near all-ones, with CNT_W=4 -> saturates at 15; perf_clr_i alongside a stall -> 0.
